// File: rtl/dct_transpose_buf_if.sv
// Handshake/bus bundle between the column DCT stage, the transpose buffer
// and the row DCT stage. The master side is the surrounding pipeline; the
// slave side is the buffer itself.
interface dct_transpose_buf_if #(
    parameter int SIZE = 10
);
    // data_in[c][r]: column c, element r of a full 8x8 block
    logic [7:0][7:0][SIZE-1:0] data_in;
    logic                      load;
    logic                      out_ready;
    // data_out[j]: element "beat" of captured column j
    logic [7:0][SIZE-1:0]      data_out;
    logic                      out_valid;
    logic                      out_first;
    logic                      out_last;
    logic                      busy;
    logic                      overflow;

    modport master (
        output data_in, load, out_ready,
        input  data_out, out_valid, out_first, out_last, busy, overflow
    );

    modport slave (
        input  data_in, load, out_ready,
        output data_out, out_valid, out_first, out_last, busy, overflow
    );
endinterface

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the column and row DCT stages.
// A whole block is captured in one edge; it then leaves one transposed
// 8-element vector per accepted beat. Two banks let capture overlap drain.
module dct_transpose_buf #(
    parameter int SIZE = 10
) (
    input  logic                clk,
    input  logic                rst,
    dct_transpose_buf_if.slave  bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

    // Block storage; contents are intentionally left unreset.
    logic [1:0][7:0][7:0][SIZE-1:0] bank;

    bank_state_t          st     [2];
    bank_state_t          st_nxt [2];
    logic                 wr_ptr, wr_ptr_nxt;
    logic                 rd_ptr, rd_ptr_nxt;
    logic [2:0]           beat, beat_nxt;
    logic                 overflow_q, overflow_nxt;

    logic                 out_valid;
    logic                 beat_acc;
    logic                 last_acc;
    logic                 load_ok;
    logic [7:0][SIZE-1:0] lane_out;

    assign out_valid = (st[rd_ptr] == FULL);
    assign beat_acc  = out_valid && bus.out_ready;
    assign last_acc  = beat_acc && (beat == 3'd7);
    // A full write bank is still usable when it is the one being freed now.
    assign load_ok   = bus.load &&
                       ((st[wr_ptr] == EMPTY) || (last_acc && (rd_ptr == wr_ptr)));

    // Control state register; asynchronous reset kills any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st[0]      <= EMPTY;
            st[1]      <= EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            beat       <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            st         <= st_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            beat       <= beat_nxt;
            overflow_q <= overflow_nxt;
        end
    end

    // Next-state: drain first, then load, so a same-cycle refill of the
    // bank being freed leaves it FULL.
    always_comb begin
        st_nxt[0]    = st[0];
        st_nxt[1]    = st[1];
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        beat_nxt     = beat;
        overflow_nxt = overflow_q;
        if (beat_acc) begin
            beat_nxt = 3'(beat + 3'd1);
            if (beat == 3'd7) begin
                st_nxt[rd_ptr] = EMPTY;
                rd_ptr_nxt     = ~rd_ptr;
            end
        end
        if (bus.load) begin
            if (load_ok) begin
                st_nxt[wr_ptr] = FULL;
                wr_ptr_nxt     = ~wr_ptr;
            end else begin
                overflow_nxt   = 1'b1;
            end
        end
    end

    // Block capture into the write bank on an accepted load.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            bank[wr_ptr] <= bus.data_in;
        end
    end

    // Per-lane transposed read: lane j emits element "beat" of column j.
    for (genvar j = 0; j < 8; j++) begin : g_lane
        assign lane_out[j] = out_valid ? bank[rd_ptr][j][beat] : '0;
    end

    assign bus.data_out  = lane_out;
    assign bus.out_valid = out_valid;
    assign bus.out_first = out_valid && (beat == 3'd0);
    assign bus.out_last  = out_valid && (beat == 3'd7);
    assign bus.busy      = (st[0] == FULL) && (st[1] == FULL);
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for the ping-pong transpose buffer: a per-cycle table of
// inputs and expected outputs, plus a hand-written reset-mid-stream sequence.
module tb_dct_transpose_buf;
    localparam int SIZE = 10;

    typedef logic [7:0][7:0][SIZE-1:0] blk_t;
    typedef logic [7:0][SIZE-1:0]      vec_t;

    typedef struct {
        logic       load;
        int         blk_in;
        logic       ready;
        logic [4:0] flags;  // {valid, first, last, busy, overflow}
        int         eblk;   // -1: data_out must be zero
        int         ek;
    } row_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    row_t tbl[$];

    always #5 clk = ~clk;

    dct_transpose_buf_if #(.SIZE(SIZE)) bus ();

    dct_transpose_buf #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Block generators: 0 ramp, 1 offset ramp, 2 negative ramp, 3 extremes.
    function automatic logic [SIZE-1:0] elem(int b, int c, int r);
        int v;
        case (b)
            0:       v = 8 * c + r;
            1:       v = 100 + 8 * c + r;
            2:       v = -(8 * c + r + 1);
            3:       v = ((c + r) % 2 != 0) ? -512 : 511;
            default: v = 0;
        endcase
        return v[SIZE-1:0];
    endfunction

    function automatic blk_t mk_blk(int b);
        blk_t t;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                t[c][r] = elem(b, c, r);
        return t;
    endfunction

    function automatic vec_t mk_vec(int b, int k);
        vec_t t;
        for (int j = 0; j < 8; j++)
            t[j] = (b < 0) ? '0 : elem(b, j, k);
        return t;
    endfunction

    task automatic add_idle(logic ld, int bi, logic rdy, logic ovf);
        row_t r;
        r.load = ld; r.blk_in = bi; r.ready = rdy;
        r.flags = {4'b0000, ovf}; r.eblk = -1; r.ek = 0;
        tbl.push_back(r);
    endtask

    task automatic add_beat(logic ld, int bi, logic rdy, int eb, int k, logic bsy, logic ovf);
        row_t r;
        r.load = ld; r.blk_in = bi; r.ready = rdy;
        r.flags = {1'b1, k == 0, k == 7, bsy, ovf}; r.eblk = eb; r.ek = k;
        tbl.push_back(r);
    endtask

    task automatic chk_flags(string name, logic [4:0] exp);
        logic [4:0] act;
        act = {bus.out_valid, bus.out_first, bus.out_last, bus.busy, bus.overflow};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s flags(v,f,l,busy,ovf): got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_data(string name, vec_t exp);
        checks++;
        if (bus.data_out !== exp) begin
            errors++;
            $display("FAIL %s data_out: got %h expected %h", name, bus.data_out, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single blocks: ramp, negative ramp, signed extremes
        for (int b = 0; b < 4; b++) begin
            if (b == 1) continue;
            add_idle(1'b1, b, 1'b1, 1'b0);
            for (int k = 0; k < 8; k++) add_beat(1'b0, 0, 1'b1, b, k, 1'b0, 1'b0);
            add_idle(1'b0, 0, 1'b1, 1'b0);
        end
        // Back-to-back: A at cycle 0, B at cycle 8, 16 gapless beats
        add_idle(1'b1, 0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) add_beat(k == 7, 1, 1'b1, 0, k, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) add_beat(1'b0, 0, 1'b1, 1, k, 1'b0, 1'b0);
        add_idle(1'b0, 0, 1'b1, 1'b0);
        // Collision: both full, C loads on A's beat 7 into A's freed bank
        add_idle(1'b1, 0, 1'b0, 1'b0);
        add_beat(1'b1, 1, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) add_beat(k == 7, 2, 1'b1, 0, k, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) add_beat(1'b0, 0, 1'b1, 1, k, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) add_beat(1'b0, 0, 1'b1, 2, k, 1'b0, 1'b0);
        add_idle(1'b0, 0, 1'b1, 1'b0);
        // Backpressure: loads at 0, 8, 16 with out_ready=0; third dropped
        add_idle(1'b1, 0, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) add_beat(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        add_beat(1'b1, 1, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 9; i < 16; i++) add_beat(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
        add_beat(1'b1, 2, 1'b0, 0, 0, 1'b1, 1'b0);
        add_beat(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) add_beat(1'b0, 0, 1'b1, 0, k, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) add_beat(1'b0, 0, 1'b1, 1, k, 1'b0, 1'b1);
        add_idle(1'b0, 0, 1'b1, 1'b1);

        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in   = '0;
        #12;
        rst = 1'b0;
        chk_flags("reset", 5'b00000);
        chk_data("reset", mk_vec(-1, 0));

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            bus.load      = tbl[i].load;
            bus.out_ready = tbl[i].ready;
            bus.data_in   = mk_blk(tbl[i].blk_in);
            #1;
            chk_flags($sformatf("row%0d", i), tbl[i].flags);
            chk_data($sformatf("row%0d", i), mk_vec(tbl[i].eblk, tbl[i].ek));
        end

        // Reset mid-stream with both banks full and overflow still set
        cyc();
        bus.load = 1'b1; bus.data_in = mk_blk(0); bus.out_ready = 1'b0;
        cyc();
        bus.data_in = mk_blk(1);
        cyc();
        bus.load = 1'b0; bus.out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        #1;
        chk_flags("pre_rst", 5'b10011);
        chk_data("pre_rst", mk_vec(0, 3));
        rst = 1'b1;
        #1;
        chk_flags("async_rst", 5'b00000);
        chk_data("async_rst", mk_vec(-1, 0));
        @(negedge clk);
        rst = 1'b0;
        cyc();
        bus.load = 1'b1; bus.data_in = mk_blk(0);
        cyc();
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk_flags($sformatf("post_rst_k%0d", k), {1'b1, k == 0, k == 7, 2'b00});
            chk_data($sformatf("post_rst_k%0d", k), mk_vec(0, k));
            cyc();
        end
        #1;
        chk_flags("post_rst_idle", 5'b00000);
        chk_data("post_rst_idle", mk_vec(-1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
